digit_timer: RTL and testbench



---
 rtl/microwave_pkg.sv | 15 +
 rtl/bcd_digit_down.sv | 27 ++
 rtl/digit_timer.sv | 145 ++++++++++++++
 tb/tb_digit_timer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad, timer and display blocks.
package microwave_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX       = 4'd9;
  localparam bcd_t SEC_TENS_WRAP = 4'd5;
  localparam bcd_t BCD_ZERO      = 4'd0;

  // True when a keypad digit is a legal BCD value.
  function automatic logic bcd_valid(input bcd_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One stage of a BCD down-counter borrow chain. When dec_i is set the digit
// decrements; a zero digit reloads to wrap_i and raises borrow_o for the next stage.
module bcd_digit_down
  import microwave_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       dec_i,
  input  logic [3:0] wrap_i,
  output logic [3:0] digit_o,
  output logic       borrow_o
);

  // Decrement-or-wrap for a single digit.
  always_comb begin
    digit_o  = digit_i;
    borrow_o = 1'b0;
    if (dec_i) begin
      if (digit_i == BCD_ZERO) begin
        digit_o  = wrap_i;
        borrow_o = 1'b1;
      end else begin
        digit_o = digit_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/digit_timer.sv
// Microwave cook-time register: keypad digit entry (M:SS shift-in), once-per-second
// countdown to 0:00 and a completion pulse.
// Build option: DIGIT_TIMER_PRESCALER_EN selects an internal TICK_DIV prescaler in
// place of the external tick input.
module digit_timer
  import microwave_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       clear,
  input  logic       count_en,
  input  logic       tick,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       zero,
  output logic       done
);

  bcd_t ones_q, ones_d;
  bcd_t tens_q, tens_d;
  bcd_t min_q, min_d;
  logic loadn_q;
  logic done_q, done_d;
  logic tick_w;

  bcd_t ones_dec, tens_dec, min_dec;
  logic ones_borrow, tens_borrow;
  logic unused_min_borrow;

`ifdef DIGIT_TIMER_PRESCALER_EN
  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            unused_tick;

  assign unused_tick = tick;

  // Prescaler runs only while cooking; a pause discards the partial second.
  always_comb begin
    cnt_d = '0;
    if (count_en) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
    end
  end

  assign tick_w = count_en && (cnt_q == CntMax);

  // Prescaler count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_tick_div;

  assign unused_tick_div = ^TICK_DIV;
  assign tick_w          = tick;
`endif

  // Borrow chain: seconds units wrap to 9, seconds tens to 5, minutes to 9.
  bcd_digit_down u_ones (
    .digit_i  (ones_q),
    .dec_i    (1'b1),
    .wrap_i   (BCD_MAX),
    .digit_o  (ones_dec),
    .borrow_o (ones_borrow)
  );

  bcd_digit_down u_tens (
    .digit_i  (tens_q),
    .dec_i    (ones_borrow),
    .wrap_i   (SEC_TENS_WRAP),
    .digit_o  (tens_dec),
    .borrow_o (tens_borrow)
  );

  bcd_digit_down u_min (
    .digit_i  (min_q),
    .dec_i    (tens_borrow),
    .wrap_i   (BCD_MAX),
    .digit_o  (min_dec),
    .borrow_o (unused_min_borrow)
  );

  logic load_evt;
  logic dec_fire;

  assign zero     = (ones_q == BCD_ZERO) && (tens_q == BCD_ZERO) && (min_q == BCD_ZERO);
  assign load_evt = loadn_q && !loadn;
  assign dec_fire = count_en && tick_w && !zero;

  // Next-state priority: clear, then countdown, then digit entry.
  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    min_d  = min_q;
    done_d = 1'b0;
    if (clear) begin
      ones_d = BCD_ZERO;
      tens_d = BCD_ZERO;
      min_d  = BCD_ZERO;
    end else if (dec_fire) begin
      ones_d = ones_dec;
      tens_d = tens_dec;
      min_d  = min_dec;
      done_d = (ones_dec == BCD_ZERO) && (tens_dec == BCD_ZERO) && (min_dec == BCD_ZERO);
    end else if (load_evt && !count_en && bcd_valid(D)) begin
      min_d  = tens_q;
      tens_d = ones_q;
      ones_d = D;
    end
  end

  // Time register, strobe edge detector and completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q  <= BCD_ZERO;
      tens_q  <= BCD_ZERO;
      min_q   <= BCD_ZERO;
      loadn_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      ones_q  <= ones_d;
      tens_q  <= tens_d;
      min_q   <= min_d;
      loadn_q <= loadn;
      done_q  <= done_d;
    end
  end

  assign sec_ones = ones_q;
  assign sec_tens = tens_q;
  assign min_ones = min_q;
  assign done     = done_q;

endmodule

// File: tb/tb_digit_timer.sv
// Self-checking bench for digit_timer: directed scenarios plus a randomized run,
// all checked against a digit-level reference model of the cook-time rules.
module tb_digit_timer;

  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1;
  logic       clear = 1'b0;
  logic       count_en = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones;
  logic       zero, done;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_min = 0, m_tens = 0, m_ones = 0, m_cnt = 0;
  bit m_lq = 1'b1, m_done = 1'b0;

  digit_timer #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .rst      (rst),
    .D        (D),
    .loadn    (loadn),
    .clear    (clear),
    .count_en (count_en),
    .tick     (tick),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .zero     (zero),
    .done     (done)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] mvec();
    return {4'(m_min), 4'(m_tens), 4'(m_ones), (m_min + m_tens + m_ones) == 0, m_done};
  endfunction

  // Advance one clock: model computes its next state from the inputs present at the edge.
  task automatic step();
    int nm, nt, no, ncnt;
    bit nd, nlq, tk;
    nm = m_min; nt = m_tens; no = m_ones; nd = 1'b0; ncnt = 0;
    if (rst) begin
      nm = 0; nt = 0; no = 0; nlq = 1'b1;
    end else begin
      nlq = loadn;
`ifdef DIGIT_TIMER_PRESCALER_EN
      tk   = count_en && (m_cnt == TD - 1);
      ncnt = count_en ? (m_cnt + 1) % TD : 0;
`else
      tk = tick;
`endif
      if (clear) begin
        nm = 0; nt = 0; no = 0;
      end else if (count_en) begin
        if (tk && (m_min + m_tens + m_ones) != 0) begin
          if (m_ones > 0) no = m_ones - 1;
          else if (m_tens > 0) begin nt = m_tens - 1; no = 9; end
          else begin nm = m_min - 1; nt = 5; no = 9; end
          nd = (nm + nt + no) == 0;
        end
      end else if (m_lq && !loadn && D <= 4'd9) begin
        nm = m_tens; nt = m_ones; no = int'(D);
      end
    end
    @(posedge clk);
    #1;
    m_min = nm; m_tens = nt; m_ones = no; m_done = nd; m_lq = nlq; m_cnt = ncnt;
  endtask

  task automatic press(input logic [3:0] d, input int hold);
    D = d;
    loadn = 1'b0;
    repeat (hold) step();
    loadn = 1'b1;
    step();
  endtask

  task automatic clear_reg();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; loadn = 1'b0; D = 4'd5; clear = 1'b0; count_en = 1'b1; tick = 1'b1;
    step();
    step();
    rst = 1'b0; loadn = 1'b1; count_en = 1'b0; tick = 1'b0;
    checks++;
    if ({min_ones, sec_tens, sec_ones, zero, done} !== {12'h000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %h:%h%h zero=%b done=%b, want 0:00 zero=1 done=0",
               min_ones, sec_tens, sec_ones, zero, done);
    end
  endtask

  task automatic test_entry();
    clear_reg();
    press(4'd1, 2);
    checks++;
    if ({min_ones, sec_tens, sec_ones} !== 12'h001) begin
      errors++;
      $display("FAIL entry_first: got %h:%h%h want 0:01", min_ones, sec_tens, sec_ones);
    end
    press(4'd3, 2);
    press(4'd0, 2);
    checks++;
    if ({min_ones, sec_tens, sec_ones, zero} !== {12'h130, 1'b0}) begin
      errors++;
      $display("FAIL entry_130: got %h:%h%h zero=%b want 1:30 zero=0",
               min_ones, sec_tens, sec_ones, zero);
    end
  endtask

  task automatic test_hold_invalid();
    clear_reg();
    press(4'd4, 20);
    checks++;
    if ({min_ones, sec_tens, sec_ones} !== 12'h004) begin
      errors++;
      $display("FAIL hold_single_shift: got %h:%h%h want 0:04", min_ones, sec_tens, sec_ones);
    end
    press(4'd12, 2);
    checks++;
    if ({min_ones, sec_tens, sec_ones} !== 12'h004) begin
      errors++;
      $display("FAIL invalid_digit: got %h:%h%h want 0:04", min_ones, sec_tens, sec_ones);
    end
  endtask

`ifndef DIGIT_TIMER_PRESCALER_EN
  task automatic test_countdown();
    logic [11:0] exp;
    clear_reg();
    press(4'd5, 2);
    count_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick_once();
      exp = 12'(5 - i);
      checks++;
      if ({min_ones, sec_tens, sec_ones, done} !== {exp, i == 5}) begin
        errors++;
        $display("FAIL countdown_tick%0d: got %h:%h%h done=%b want %h done=%b",
                 i, min_ones, sec_tens, sec_ones, done, exp, i == 5);
      end
    end
    checks++;
    if (zero !== 1'b1) begin
      errors++;
      $display("FAIL countdown_zero: got %b want 1", zero);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got %b want 0", done);
    end
    tick_once();
    checks++;
    if ({min_ones, sec_tens, sec_ones, done} !== {12'h000, 1'b0}) begin
      errors++;
      $display("FAIL tick_at_zero: got %h:%h%h done=%b want 0:00 done=0",
               min_ones, sec_tens, sec_ones, done);
    end
    count_en = 1'b0;
  endtask

  task automatic test_borrow();
    clear_reg();
    press(4'd1, 1); press(4'd0, 1); press(4'd0, 1);
    count_en = 1'b1;
    tick_once();
    count_en = 1'b0;
    checks++;
    if ({min_ones, sec_tens, sec_ones} !== 12'h059) begin
      errors++;
      $display("FAIL borrow_100: got %h:%h%h want 0:59", min_ones, sec_tens, sec_ones);
    end
    clear_reg();
    press(4'd9, 1); press(4'd9, 1);
    count_en = 1'b1;
    tick_once();
    checks++;
    if ({min_ones, sec_tens, sec_ones} !== 12'h098) begin
      errors++;
      $display("FAIL count_099: got %h:%h%h want 0:98", min_ones, sec_tens, sec_ones);
    end
    repeat (10) tick_once();
    count_en = 1'b0;
    checks++;
    if ({min_ones, sec_tens, sec_ones} !== 12'h088) begin
      errors++;
      $display("FAIL count_088: got %h:%h%h want 0:88", min_ones, sec_tens, sec_ones);
    end
  endtask

  task automatic test_count_en_block();
    clear_reg();
    press(4'd1, 1); press(4'd0, 1);
    count_en = 1'b1;
    press(4'd7, 2);
    checks++;
    if ({min_ones, sec_tens, sec_ones} !== 12'h010) begin
      errors++;
      $display("FAIL entry_blocked: got %h:%h%h want 0:10", min_ones, sec_tens, sec_ones);
    end
    clear = 1'b1; tick = 1'b1;
    step();
    clear = 1'b0; tick = 1'b0;
    checks++;
    if ({min_ones, sec_tens, sec_ones, done} !== {12'h000, 1'b0}) begin
      errors++;
      $display("FAIL clear_over_tick: got %h:%h%h done=%b want 0:00 done=0",
               min_ones, sec_tens, sec_ones, done);
    end
    count_en = 1'b0;
  endtask
`else
  task automatic test_prescaler();
    clear_reg();
    press(4'd2, 1);
    count_en = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      step();
      if (c == 9 || c == 10 || c == 20 || c == 21) begin
        checks++;
        if ({min_ones, sec_tens, sec_ones, done} !==
            {(c < 10) ? 12'h002 : (c < 20) ? 12'h001 : 12'h000, c == 20}) begin
          errors++;
          $display("FAIL prescale_cycle%0d: got %h:%h%h done=%b", c, min_ones, sec_tens,
                   sec_ones, done);
        end
      end
    end
    count_en = 1'b0;
    clear_reg();
    press(4'd2, 1);
    count_en = 1'b1;
    repeat (15) step();
    count_en = 1'b0;
    repeat (3) step();
    count_en = 1'b1;
    repeat (9) step();
    checks++;
    if ({min_ones, sec_tens, sec_ones} !== 12'h001) begin
      errors++;
      $display("FAIL pause_discard: got %h:%h%h want 0:01", min_ones, sec_tens, sec_ones);
    end
    step();
    checks++;
    if ({min_ones, sec_tens, sec_ones, done} !== {12'h000, 1'b1}) begin
      errors++;
      $display("FAIL pause_resume: got %h:%h%h done=%b want 0:00 done=1",
               min_ones, sec_tens, sec_ones, done);
    end
    count_en = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      clear    = ($urandom_range(0, 49) == 0);
      loadn    = ($urandom_range(0, 2) != 0);
      D        = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                             : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 19) == 0) count_en = ~count_en;
      tick     = ($urandom_range(0, 2) == 0);
      step();
      checks++;
      if ({min_ones, sec_tens, sec_ones, zero, done} !== mvec()) begin
        errors++;
        $display("FAIL random_%0d: got %h:%h%h z=%b d=%b want %h", i, min_ones, sec_tens,
                 sec_ones, zero, done, mvec());
      end
    end
    rst = 1'b0; clear = 1'b0; loadn = 1'b1; count_en = 1'b0; tick = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_entry();
    test_hold_invalid();
`ifndef DIGIT_TIMER_PRESCALER_EN
    test_countdown();
    test_borrow();
    test_count_en_block();
`else
    test_prescaler();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
